// File: rtl/sga_pkg.sv
// Shared types and helpers for the Snake Game Arcade move datapath.
package sga_pkg;

  localparam int unsigned GRID  = 6;
  localparam int unsigned POS_W = 6;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_HEAD,
    ST_CALC,
    ST_RD_SEG,
    ST_WR_SEG,
    ST_WR_HEAD,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [2:0] y;
    logic [2:0] x;
  } pos_t;

  typedef struct packed {
    logic off_grid;
    pos_t pos;
  } step_t;

  // Opposing directions differ only in bit 0.
  function automatic dir_t opposite_dir(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

  // One head step; off_grid flags a move that would leave the playfield.
  function automatic step_t step_pos(input pos_t cur, input dir_t d);
    step_t s;
    s.off_grid = 1'b0;
    s.pos      = cur;
    case (d)
      DIR_UP: begin
        if (cur.y >= 3'(GRID - 1)) s.off_grid = 1'b1;
        else s.pos.y = cur.y + 3'd1;
      end
      DIR_DOWN: begin
        if (cur.y == 3'd0) s.off_grid = 1'b1;
        else s.pos.y = cur.y - 3'd1;
      end
      DIR_LEFT: begin
        if (cur.x == 3'd0) s.off_grid = 1'b1;
        else s.pos.x = cur.x - 3'd1;
      end
      default: begin
        if (cur.x >= 3'(GRID - 1)) s.off_grid = 1'b1;
        else s.pos.x = cur.x + 3'd1;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sga_move_sequencer_timer.sv
// Game tick generator plus play-time move counter with a sticky end flag.
module sga_tick_timer #(
  parameter int unsigned TICK_CYCLES     = 25_000_000,
  parameter int unsigned PLAY_TIME_TICKS = 255
) (
  input  logic clock,
  input  logic restart,
  input  logic enable,
  output logic tick_c,
  output logic end_play_time
);

  localparam int unsigned CW = $clog2(TICK_CYCLES);
  localparam int unsigned MW = $clog2(PLAY_TIME_TICKS + 1);

  logic [CW-1:0] tick_cnt;
  logic [MW-1:0] move_cnt;

  assign tick_c = enable && (tick_cnt == CW'(TICK_CYCLES - 1));

  // Counter freezes while paused; move count saturates once time is up.
  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      tick_cnt      <= '0;
      move_cnt      <= '0;
      end_play_time <= 1'b0;
    end else if (enable) begin
      if (tick_c) begin
        tick_cnt <= '0;
        if (move_cnt != MW'(PLAY_TIME_TICKS)) move_cnt <= move_cnt + MW'(1);
        if (move_cnt == MW'(PLAY_TIME_TICKS - 1)) end_play_time <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sga_move_sequencer.sv
// Per-tick snake move: next head, body shift through memory, hit detection.
module sga_move_sequencer
  import sga_pkg::*;
#(
  parameter int unsigned TICK_CYCLES     = 25_000_000,
  parameter int unsigned PLAY_TIME_TICKS = 255,
  parameter int unsigned MAX_SIZE        = 16
) (
  input  logic                        clock,
  input  logic                        restart,
  input  logic                        enable,
  input  logic [3:0]                  buttons,
  input  logic [$clog2(MAX_SIZE)-1:0] size,
  input  logic [POS_W-1:0]            apple_pos,
  input  logic [POS_W-1:0]            mem_rdata,
  output logic [$clog2(MAX_SIZE)-1:0] mem_addr,
  output logic [POS_W-1:0]            mem_wdata,
  output logic                        mem_we,
  output logic                        busy,
  output logic                        move_done,
  output logic                        is_at_apple,
  output logic                        is_at_border,
  output logic                        is_at_body,
  output logic                        end_play_time,
  output logic [1:0]                  db_dir
);

  localparam int unsigned AW = $clog2(MAX_SIZE);
  localparam int unsigned NW = AW + 1;

  state_t          state_q, state_d;
  dir_t            dir_q;
  dir_t            btn_dir;
  logic            btn_valid;
  logic            tick_c;
  logic [NW-1:0]   n_q, n_d;
  logic [NW-1:0]   idx_q, idx_d;
  logic [NW-1:0]   start_idx;
  pos_t            head_q, head_d;
  step_t           step;
  logic            pend_apple_q, pend_apple_d;
  logic            pend_body_q, pend_body_d;
  logic [AW-1:0]   addr_d;
  logic [POS_W-1:0] wdata_q, wdata_d;
  logic            we_d, busy_d, done_d;
  logic            apple_d, border_d, body_d;

  sga_tick_timer #(
    .TICK_CYCLES     (TICK_CYCLES),
    .PLAY_TIME_TICKS (PLAY_TIME_TICKS)
  ) u_timer (
    .clock         (clock),
    .restart       (restart),
    .enable        (enable),
    .tick_c        (tick_c),
    .end_play_time (end_play_time)
  );

  // Exactly one pressed button selects a candidate direction.
  always_comb begin
    btn_valid = 1'b1;
    btn_dir   = DIR_RIGHT;
    case (buttons)
      4'b1000: btn_dir = DIR_UP;
      4'b0100: btn_dir = DIR_DOWN;
      4'b0010: btn_dir = DIR_LEFT;
      4'b0001: btn_dir = DIR_RIGHT;
      default: btn_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      dir_q <= DIR_RIGHT;
    end else if (enable && btn_valid && (btn_dir != opposite_dir(dir_q))) begin
      dir_q <= btn_dir;
    end
  end

  assign db_dir = dir_q;

  // Segment copies forward the read data straight into the write port.
  assign mem_wdata = (state_q == ST_WR_SEG) ? mem_rdata : wdata_q;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    idx_d        = idx_q;
    head_d       = head_q;
    pend_apple_d = pend_apple_q;
    pend_body_d  = pend_body_q;
    addr_d       = mem_addr;
    wdata_d      = wdata_q;
    we_d         = 1'b0;
    busy_d       = busy;
    done_d       = 1'b0;
    apple_d      = is_at_apple;
    border_d     = is_at_border;
    body_d       = is_at_body;
    step         = step_pos(pos_t'(mem_rdata), dir_q);
    // Growing keeps the old tail by starting the shift one slot further out.
    start_idx    = ((step.pos == pos_t'(apple_pos)) && (n_q < NW'(MAX_SIZE))) ?
                   n_q : n_q - NW'(1);

    case (state_q)
      ST_IDLE: begin
        if (tick_c) begin
          state_d      = ST_RD_HEAD;
          busy_d       = 1'b1;
          addr_d       = '0;
          apple_d      = 1'b0;
          border_d     = 1'b0;
          body_d       = 1'b0;
          pend_apple_d = 1'b0;
          pend_body_d  = 1'b0;
          n_d          = (size == '0) ? NW'(1) : NW'(size);
        end
      end
      ST_RD_HEAD: state_d = ST_CALC;
      ST_CALC: begin
        if (step.off_grid) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          border_d = 1'b1;
        end else begin
          head_d       = step.pos;
          pend_apple_d = (step.pos == pos_t'(apple_pos));
          idx_d        = start_idx;
          if (start_idx == '0) begin
            state_d = ST_WR_HEAD;
            addr_d  = '0;
            wdata_d = step.pos;
            we_d    = 1'b1;
          end else begin
            state_d = ST_RD_SEG;
            addr_d  = AW'(start_idx - NW'(1));
          end
        end
      end
      ST_RD_SEG: begin
        state_d = ST_WR_SEG;
        addr_d  = AW'(idx_q);
        we_d    = 1'b1;
      end
      ST_WR_SEG: begin
        // The old tail vacates its cell, so only segments 0..n-2 can collide.
        if ((idx_q < n_q) && (pos_t'(mem_rdata) == head_q)) pend_body_d = 1'b1;
        idx_d = idx_q - NW'(1);
        if (idx_q == NW'(1)) begin
          state_d = ST_WR_HEAD;
          addr_d  = '0;
          wdata_d = head_q;
          we_d    = 1'b1;
        end else begin
          state_d = ST_RD_SEG;
          addr_d  = AW'(idx_q - NW'(2));
        end
      end
      ST_WR_HEAD: begin
        state_d  = ST_DONE;
        done_d   = 1'b1;
        apple_d  = pend_apple_q;
        border_d = 1'b0;
        body_d   = pend_body_q;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      idx_q        <= '0;
      head_q       <= '0;
      pend_apple_q <= 1'b0;
      pend_body_q  <= 1'b0;
      mem_addr     <= '0;
      wdata_q      <= '0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      move_done    <= 1'b0;
      is_at_apple  <= 1'b0;
      is_at_border <= 1'b0;
      is_at_body   <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      head_q       <= head_d;
      pend_apple_q <= pend_apple_d;
      pend_body_q  <= pend_body_d;
      mem_addr     <= addr_d;
      wdata_q      <= wdata_d;
      mem_we       <= we_d;
      busy         <= busy_d;
      move_done    <= done_d;
      is_at_apple  <= apple_d;
      is_at_border <= border_d;
      is_at_body   <= body_d;
    end
  end

endmodule
